// File: rtl/uart_rx_word.sv
// uart_rx_word: 8N1 serial receiver that packs four bytes (LSB first) into a
// 32-bit word, with framing-error, inter-byte timeout and glitch rejection.
module uart_rx_word #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic        i_Clock,
    input  logic        i_Rst_n,
    input  logic        i_Rx_Serial,
    output logic [31:0] o_Rx_Word,
    output logic        o_Rx_DV,
    output logic        o_Rx_Active,
    output logic        o_Rx_Frame_Err,
    output logic        o_Rx_Timeout
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned TMO_W  = 32;
    localparam int unsigned WORD_W = 32;

    // Mid-start check point, last count of a bit period, and idle limit
    localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_BITS * CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_e;

    state_e              state_q,    state_d;
    logic                rx_meta_q,  rx_meta_d;
    logic                rx_s_q,     rx_s_d;
    logic [CNT_W-1:0]    clk_cnt_q,  clk_cnt_d;
    logic [2:0]          bit_idx_q,  bit_idx_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [TMO_W-1:0]    tmo_cnt_q,  tmo_cnt_d;
    logic [7:0]          byte_q,     byte_d;
    logic [WORD_W-1:0]   stage_q,    stage_d;
    logic [WORD_W-1:0]   word_q,     word_d;
    logic                dv_q,       dv_d;
    logic                active_q,   active_d;
    logic                ferr_q,     ferr_d;
    logic                tmo_q,      tmo_d;

    // Next-state, datapath and strobe logic
    always_comb begin
        state_d    = state_q;
        rx_meta_d  = i_Rx_Serial;
        rx_s_d     = rx_meta_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        tmo_cnt_d  = '0;
        byte_d     = byte_q;
        stage_d    = stage_q;
        word_d     = word_q;
        dv_d       = 1'b0;
        ferr_d     = 1'b0;
        tmo_d      = 1'b0;

        // Inter-byte timeout: only counts while idling inside a partial word.
        // Handled before the FSM so a coincident start bit sees byte index 0.
        if ((state_q == S_IDLE) && (byte_idx_q != 2'd0)) begin
            if ((tmo_cnt_q + TMO_W'(1)) == TMO_LIMIT) begin
                tmo_d      = 1'b1;
                byte_idx_d = 2'd0;
                tmo_cnt_d  = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                bit_idx_d = 3'd0;
                if (!rx_s_q) begin
                    clk_cnt_d = '0;
                    state_d   = S_START;
                end
            end

            S_START: begin
                if (clk_cnt_q == HALF_CNT) begin
                    if (!rx_s_q) begin
                        clk_cnt_d = '0;
                        bit_idx_d = 3'd0;
                        state_d   = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (clk_cnt_q == LAST_CNT) begin
                    clk_cnt_d         = '0;
                    byte_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (clk_cnt_q == LAST_CNT) begin
                    clk_cnt_d = '0;
                    if (rx_s_q) begin
                        // Good stop bit: drop the byte into its lane
                        case (byte_idx_q)
                            2'd0:    stage_d[7:0]   = byte_q;
                            2'd1:    stage_d[15:8]  = byte_q;
                            2'd2:    stage_d[23:16] = byte_q;
                            default: stage_d[31:24] = byte_q;
                        endcase
                        if (byte_idx_q == 2'd3) begin
                            word_d     = stage_d;
                            dv_d       = 1'b1;
                            byte_idx_d = 2'd0;
                        end else begin
                            byte_idx_d = byte_idx_q + 2'd1;
                        end
                        state_d = S_IDLE;
                    end else begin
                        ferr_d     = 1'b1;
                        byte_idx_d = 2'd0;
                        state_d    = S_WAIT_HIGH;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            S_WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        active_d = (state_d != S_IDLE);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state_q    <= S_IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            tmo_cnt_q  <= '0;
            byte_q     <= '0;
            stage_q    <= '0;
            word_q     <= '0;
            dv_q       <= 1'b0;
            active_q   <= 1'b0;
            ferr_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx_meta_d;
            rx_s_q     <= rx_s_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            tmo_cnt_q  <= tmo_cnt_d;
            byte_q     <= byte_d;
            stage_q    <= stage_d;
            word_q     <= word_d;
            dv_q       <= dv_d;
            active_q   <= active_d;
            ferr_q     <= ferr_d;
            tmo_q      <= tmo_d;
        end
    end

    assign o_Rx_Word      = word_q;
    assign o_Rx_DV        = dv_q;
    assign o_Rx_Active    = active_q;
    assign o_Rx_Frame_Err = ferr_q;
    assign o_Rx_Timeout   = tmo_q;

endmodule
